// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master sequencer: FSM state encoding,
// SPI mode constants ({CPOL,CPHA}) and the sample-edge helper.
package spi_master_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SETUP = 3'd2,
      XFER  = 3'd3,
      HOLD  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Modes with CPHA=0 capture data on the leading SCLK edge.
   function automatic logic sample_on_leading(input logic [1:0] mode);
      logic result;
      result = 1'b0;
      case (mode)
         MODE0, MODE2: result = 1'b1;
         MODE1, MODE3: result = 1'b0;
         default:      result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: emits a one-cycle tick every div+1 clocks,
// restarting from zero whenever restart is held.
module spi_clk_div #(
   parameter int DivW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            restart,
   input  logic [DivW-1:0] div,
   output logic            tick
);

   logic [DivW-1:0] cnt_reg;

   // Equality compare against div means div = all-ones never needs a wrap.
   assign tick = !restart && (cnt_reg == div);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (restart || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: one half-duplex WordLen-bit word per Start, driving
// SCLK/CS_n and the shift-register strobes for SPI modes 0-3.
module spi_master_ctrl
   import spi_master_ctrl_pkg::*;
#(
   parameter int WordLen = 8,
   parameter int DivW    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            Start,
   input  logic            RW,
   input  logic            CPOL,
   input  logic            CPHA,
   input  logic [DivW-1:0] ClkDiv,
   output logic            SCLK,
   output logic            CS_n,
   output logic            EnPISO,
   output logic            LoadPISO,
   output logic            ShiftEdge,
   output logic            WordFlg,
   output logic            TristateMode,
   output logic            Busy,
   output logic            Done
);

   localparam int BitW  = $clog2(WordLen + 1);
   localparam int EdgeW = $clog2(2 * WordLen + 1);
   localparam logic [EdgeW-1:0] LAST_EDGE = EdgeW'(2 * WordLen);
   localparam logic [EdgeW-1:0] FIRST_EDGE = EdgeW'(1);
   localparam logic [BitW-1:0]  FULL_BITS = BitW'(WordLen);

   state_t            state_reg;
   logic              rw_reg;
   logic              cpol_reg;
   logic              cpha_reg;
   logic [DivW-1:0]   div_reg;
   logic [EdgeW-1:0]  edge_reg;
   logic [BitW-1:0]   bit_reg;

   logic [EdgeW-1:0]  next_edge;
   logic              leading_edge;
   logic              sample_edge;
   logic              launch_skip;
   logic              div_restart;
   logic              div_tick;

   // Odd-numbered edges are leading edges.
   assign next_edge    = edge_reg + 1'b1;
   assign leading_edge = next_edge[0];
   assign sample_edge  = sample_on_leading({cpol_reg, cpha_reg}) ? leading_edge : ~leading_edge;

   // Write launches skip the edge before the first sample (bit 0 is preloaded)
   // and the final trailing edge in CPHA=0, leaving WordLen-1 shifts.
   assign launch_skip = (cpha_reg && (next_edge == FIRST_EDGE)) ||
                        (!cpha_reg && (next_edge == LAST_EDGE));

   assign div_restart = (state_reg == IDLE) || (state_reg == LOAD) || (state_reg == DONE);

   spi_clk_div #(
      .DivW (DivW)
   ) u_clk_div (
      .clk     (clk),
      .rst     (rst),
      .restart (div_restart),
      .div     (div_reg),
      .tick    (div_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         rw_reg       <= 1'b0;
         cpol_reg     <= 1'b0;
         cpha_reg     <= 1'b0;
         div_reg      <= '0;
         edge_reg     <= '0;
         bit_reg      <= '0;
         SCLK         <= 1'b0;
         CS_n         <= 1'b1;
         EnPISO       <= 1'b0;
         LoadPISO     <= 1'b0;
         ShiftEdge    <= 1'b0;
         WordFlg      <= 1'b0;
         TristateMode <= 1'b0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
      end else begin
         LoadPISO  <= 1'b0;
         ShiftEdge <= 1'b0;
         Done      <= 1'b0;
         if (bit_reg == FULL_BITS) begin
            WordFlg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               SCLK <= cpol_reg;
               if (Start) begin
                  rw_reg       <= RW;
                  cpol_reg     <= CPOL;
                  cpha_reg     <= CPHA;
                  div_reg      <= ClkDiv;
                  SCLK         <= CPOL;
                  CS_n         <= 1'b0;
                  EnPISO       <= 1'b1;
                  TristateMode <= RW;
                  LoadPISO     <= RW;
                  Busy         <= 1'b1;
                  state_reg    <= LOAD;
               end
            end

            LOAD: begin
               state_reg <= SETUP;
            end

            SETUP: begin
               if (div_tick) begin
                  state_reg <= XFER;
               end
            end

            XFER: begin
               if (div_tick) begin
                  edge_reg  <= next_edge;
                  SCLK      <= ~SCLK;
                  ShiftEdge <= rw_reg ? (!sample_edge && !launch_skip) : sample_edge;
                  if (sample_edge) begin
                     bit_reg <= bit_reg + 1'b1;
                  end
                  if (next_edge == LAST_EDGE) begin
                     state_reg <= HOLD;
                  end
               end
            end

            HOLD: begin
               if (div_tick) begin
                  CS_n         <= 1'b1;
                  EnPISO       <= 1'b0;
                  TristateMode <= 1'b0;
                  Done         <= 1'b1;
                  Busy         <= 1'b0;
                  state_reg    <= DONE;
               end
            end

            DONE: begin
               SCLK      <= cpol_reg;
               WordFlg   <= 1'b0;
               edge_reg  <= '0;
               bit_reg   <= '0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed and randomized bench for spi_master_ctrl, checked against a
// per-word timing/strobe model derived from the SPI mode rules.
module tb_spi_master_ctrl;

   localparam int W  = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          Start;
   logic          RW;
   logic          CPOL;
   logic          CPHA;
   logic [DW-1:0] ClkDiv;
   logic          SCLK;
   logic          CS_n;
   logic          EnPISO;
   logic          LoadPISO;
   logic          ShiftEdge;
   logic          WordFlg;
   logic          TristateMode;
   logic          Busy;
   logic          Done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spi_master_ctrl #(
      .WordLen (W),
      .DivW    (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .Start        (Start),
      .RW           (RW),
      .CPOL         (CPOL),
      .CPHA         (CPHA),
      .ClkDiv       (ClkDiv),
      .SCLK         (SCLK),
      .CS_n         (CS_n),
      .EnPISO       (EnPISO),
      .LoadPISO     (LoadPISO),
      .ShiftEdge    (ShiftEdge),
      .WordFlg      (WordFlg),
      .TristateMode (TristateMode),
      .Busy         (Busy),
      .Done         (Done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edge e (1..2W): odd = leading. Sample edge is leading for CPHA=0.
   function automatic bit is_sample(input bit cpha, input int e);
      return cpha ? (e % 2 == 0) : (e % 2 == 1);
   endfunction

   function automatic bit exp_shift(input bit rw, input bit cpha, input int e);
      if (!rw) return is_sample(cpha, e);
      if (is_sample(cpha, e)) return 1'b0;
      if (cpha && e == 1) return 1'b0;
      if (!cpha && e == 2 * W) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_word(input bit rw, input bit cpol, input bit cpha, input int div,
                           input int again_edge, input int abort_edge, input string tag);
      int cyc, edges, shifts, shift_bad, gap_bad, first_edge, last_edge, cs_low;
      int loads, tri_bad, idle_bad, busy_bad, wf_bad, samples, wf_cyc, dones, budget;
      bit prev_sclk, prev_cs, aborted, again_done;
      cyc = 0; edges = 0; shifts = 0; shift_bad = 0; gap_bad = 0; first_edge = -1;
      last_edge = 0; cs_low = 0; loads = 0; tri_bad = 0; idle_bad = 0; busy_bad = 0;
      wf_bad = 0; samples = 0; wf_cyc = -1; dones = 0; aborted = 0; again_done = 0;
      budget = (2 * W + 4) * (div + 1) + 20;

      RW = rw; CPOL = cpol; CPHA = cpha; ClkDiv = DW'(div); Start = 1'b1;
      step();
      Start = 1'b0;
      // Scramble the configuration inputs: the word must use the captured copy.
      RW = 1'($urandom); CPOL = 1'($urandom); CPHA = 1'($urandom); ClkDiv = DW'($urandom);
      chk({tag, "_busy_after_start"}, 32'(Busy), 32'(1));
      prev_sclk = SCLK;
      prev_cs   = 1'b1;

      while (cyc < budget && dones == 0 && !aborted) begin
         if (!CS_n) cs_low++;
         if (LoadPISO === 1'b1) loads++;
         if (!CS_n && (TristateMode !== rw || EnPISO !== 1'b1)) tri_bad++;
         if (SCLK !== prev_sclk) begin
            edges++;
            if (edges == 1) first_edge = cyc;
            else if (cyc - last_edge != div + 1) gap_bad++;
            last_edge = cyc;
            if (ShiftEdge !== exp_shift(rw, cpha, edges)) shift_bad++;
            if (is_sample(cpha, edges)) begin
               samples++;
               if (samples == W) wf_cyc = cyc;
            end
         end else if (ShiftEdge !== 1'b0) begin
            shift_bad++;
         end
         if (ShiftEdge === 1'b1) shifts++;
         if (edges == 0 && SCLK !== cpol) idle_bad++;
         if (WordFlg !== (wf_cyc >= 0 && cyc > wf_cyc)) wf_bad++;
         if (Done === 1'b1) begin
            dones++;
            chk({tag, "_cs_at_done"}, 32'(CS_n), 32'(1));
            chk({tag, "_cs_before_done"}, 32'(prev_cs), 32'(0));
            chk({tag, "_busy_at_done"}, 32'(Busy), 32'(0));
         end else if (Busy !== 1'b1) begin
            busy_bad++;
         end
         prev_sclk = SCLK;
         prev_cs   = CS_n;
         if (Start) Start = 1'b0;
         if (again_edge > 0 && edges == again_edge && !again_done) begin
            Start = 1'b1; RW = ~rw; CPOL = ~cpol; CPHA = ~cpha; ClkDiv = DW'(div + 3);
            again_done = 1'b1;
         end
         if (abort_edge > 0 && edges == abort_edge) begin
            rst = 1'b1;
            aborted = 1'b1;
         end
         step();
         cyc++;
      end

      if (aborted) begin
         chk({tag, "_abort_cs"}, 32'(CS_n), 32'(1));
         chk({tag, "_abort_sclk"}, 32'(SCLK), 32'(0));
         chk({tag, "_abort_busy"}, 32'(Busy), 32'(0));
         chk({tag, "_abort_done"}, 32'(Done), 32'(0));
         chk({tag, "_abort_en"}, 32'(EnPISO), 32'(0));
         rst = 1'b0;
         dones = 0;
         repeat ((2 * W + 4) * (div + 1) + 20) begin
            step();
            if (Done === 1'b1 || CS_n !== 1'b1) dones++;
         end
         chk({tag, "_abort_quiet"}, 32'(dones), 32'(0));
      end else begin
         chk({tag, "_done_seen"}, 32'(dones), 32'(1));
         chk({tag, "_edges"}, 32'(edges), 32'(2 * W));
         chk({tag, "_cs_low_cycles"}, 32'(cs_low), 32'(1 + (2 * W + 2) * (div + 1)));
         chk({tag, "_first_edge_cyc"}, 32'(first_edge), 32'(2 * div + 3));
         chk({tag, "_half_period"}, 32'(gap_bad), 32'(0));
         chk({tag, "_shift_pos"}, 32'(shift_bad), 32'(0));
         chk({tag, "_shift_cnt"}, 32'(shifts), 32'(rw ? W - 1 : W));
         chk({tag, "_loads"}, 32'(loads), 32'(rw ? 1 : 0));
         chk({tag, "_tristate_en"}, 32'(tri_bad), 32'(0));
         chk({tag, "_sclk_idle"}, 32'(idle_bad), 32'(0));
         chk({tag, "_wordflg"}, 32'(wf_bad), 32'(0));
         chk({tag, "_busy"}, 32'(busy_bad), 32'(0));
         step();
         chk({tag, "_done_one_cycle"}, 32'(Done), 32'(0));
         chk({tag, "_idle_cs"}, 32'(CS_n), 32'(1));
         chk({tag, "_idle_sclk"}, 32'(SCLK), 32'(cpol));
         chk({tag, "_idle_wordflg"}, 32'(WordFlg), 32'(0));
      end
      $display("word %s rw=%0d mode=%0d div=%0d edges=%0d shifts=%0d cs_low=%0d",
               tag, rw, {cpol, cpha}, div, edges, shifts, cs_low);
   endtask

   initial begin
      int dones, falls, loads, gap, gap_at_fall, stray;
      bit in_gap, prev;

      rst = 1'b1; Start = 1'b0; RW = 1'b0; CPOL = 1'b0; CPHA = 1'b0; ClkDiv = '0;
      repeat (3) step();
      chk("rst_sclk", 32'(SCLK), 32'(0));
      chk("rst_cs", 32'(CS_n), 32'(1));
      chk("rst_en", 32'(EnPISO), 32'(0));
      chk("rst_load", 32'(LoadPISO), 32'(0));
      chk("rst_shift", 32'(ShiftEdge), 32'(0));
      chk("rst_wordflg", 32'(WordFlg), 32'(0));
      chk("rst_tri", 32'(TristateMode), 32'(0));
      chk("rst_busy", 32'(Busy), 32'(0));
      chk("rst_done", 32'(Done), 32'(0));
      rst = 1'b0;
      repeat (2) step();

      run_word(1'b1, 1'b0, 1'b0, 1,   0, 0, "m0_wr_div1");
      run_word(1'b0, 1'b1, 1'b1, 0,   0, 0, "m3_rd_div0");
      run_word(1'b1, 1'b1, 1'b0, 2,   5, 0, "m2_wr_start_again");
      run_word(1'b1, 1'b0, 1'b1, 1,   0, 9, "m1_wr_abort");
      run_word(1'b1, 1'b0, 1'b1, 1,   0, 0, "m1_wr_after_abort");

      // Back-to-back words with Start held high.
      RW = 1'b1; CPOL = 1'b0; CPHA = 1'b0; ClkDiv = '0; Start = 1'b1;
      dones = 0; falls = 0; loads = 0; gap = 0; gap_at_fall = -1; in_gap = 0; prev = 1'b1;
      for (int c = 0; c < 400 && dones < 2; c++) begin
         step();
         if (LoadPISO === 1'b1) loads++;
         if (Done === 1'b1) begin
            dones++;
            in_gap = 1'b1;
         end
         if (in_gap && CS_n === 1'b1) gap++;
         if (prev && CS_n === 1'b0) begin
            falls++;
            in_gap = 1'b0;
            if (falls == 2) begin
               gap_at_fall = gap;
               Start = 1'b0;
            end
         end
         prev = CS_n;
      end
      Start = 1'b0;
      chk("b2b_dones", 32'(dones), 32'(2));
      chk("b2b_words", 32'(falls), 32'(2));
      chk("b2b_loads", 32'(loads), 32'(2));
      chk("b2b_cs_high_gap", 32'(gap_at_fall), 32'(2));
      stray = 0;
      repeat (30) begin
         step();
         if (CS_n !== 1'b1) stray++;
      end
      chk("b2b_no_third_word", 32'(stray), 32'(0));
      $display("word b2b dones=%0d falls=%0d gap=%0d", dones, falls, gap_at_fall);

      run_word(1'b0, 1'b1, 1'b0, 255, 0, 0, "m2_rd_div255");

      for (int i = 0; i < 6; i++) begin
         run_word(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 0, 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
